alu_rs: RTL and testbench
=========================

# alu_rs

Reservation station on the consumer end of the CDB broadcast produced by the reorder buffer. Holds up to `RS_SIZE` decoded ALU instructions, snoops every CDB write and captures operands whose producer tag matches, and dispatches one operand-complete instruction per cycle to the ALU. The ALU result then returns to the ROB write port under the same destination name and tag.

## Interface
- `RS_SIZE`, 8: number of entries.
- `DATA_W`, 32: operand/data width (`DataBus`).
- `TAG_W`, 4: producer tag width (`TagBus`).
- `NAME_W`, 5: destination register name width (`NameBus`).
- `OP_W`, 6: ALU opcode width.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-low (reset when `rst`==0 at a rising edge).
- `enIssue`  in  1  issue request from decoder, valid for the current cycle.
- `issueOp`  in  OP_W  opcode.
- `issueData1` / `issueData2`  in  DATA_W  operand values, meaningful when matching tag is `tagFree`.
- `issueTag1` / `issueTag2`  in  TAG_W  operand producer tags; `tagFree` means value already valid.
- `issueName`  in  NAME_W  destination register name.
- `issueTag`  in  TAG_W  destination tag of this instruction.
- `rsFull`  out  1  combinational; 1 when every entry is busy.
- `enCDBWrt`  in  1  CDB broadcast valid.
- `CDBwrtTag`  in  TAG_W  broadcast producer tag.
- `CDBwrtData`  in  DATA_W  broadcast value.
- `aluEn`  out  1  registered dispatch valid, one cycle pulse per instruction.
- `aluOp`, `aluSrc1`, `aluSrc2`, `aluName`, `aluTag`  out  OP_W/DATA_W/DATA_W/NAME_W/TAG_W  registered dispatch payload.

## Operation
- Entry state: `busy`, op, `V1/Q1`, `V2/Q2`, dest name, dest tag. Operand k ready iff `Qk == tagFree`.
- Issue: if `enIssue && !rsFull`, write the lowest-index non-busy entry, set `busy`. If `enIssue && rsFull`, request dropped, no state change (upstream must not do this; checked by assertion).
- Issue-time forwarding: if `enCDBWrt` and `issueTagk == CDBwrtTag != tagFree`, store `CDBwrtData` and `Qk = tagFree` for that operand.
- Snoop: each cycle with `enCDBWrt`, every busy entry with `Qk == CDBwrtTag` (and `CDBwrtTag != tagFree`) loads `Vk = CDBwrtData`, `Qk = tagFree`. Both operands of one entry may capture in the same cycle.
- Ready vector = `busy & (Q1==tagFree) & (Q2==tagFree)`, computed from registered state only.
- Dispatch: lowest-index ready entry is selected; at the edge its payload loads into `alu*` registers, `aluEn`=1, entry `busy` cleared. No ready entry: `aluEn`=0, payload registers hold previous value.
- `rsFull` = AND of registered `busy`; an entry freed by dispatch at edge E is issuable only in the cycle after E.
- Issue, snoop and dispatch on distinct entries occur in the same cycle without interaction.

## Timing
- Reset (rst==0 at edge): all `busy`=0, `Q*`=`tagFree`; `aluEn`=0, `aluOp`=0, `aluSrc1/2`=`dataFree`, `aluName`=`nameFree`, `aluTag`=`tagFree`; `rsFull`=0 after that edge. Reset mid-operation discards all entries and any pending dispatch; issue/CDB inputs during reset ignored.
- Issue with both operands ready sampled at edge E0 → `aluEn`=1 in cycle following E1 (one-cycle latency through the station).
- Operand captured from CDB at edge E → earliest dispatch at E+1.
- Throughput: one dispatch per cycle, one issue per cycle.

## Structure
- Shared `defines.v`: `tagFree`, `nameFree`, `dataFree`, `Enable/Disable`, `DataBus/TagBus/NameBus`, ALU opcode constants.
- One sub-module: `lowbit_sel` (parameter width; one-hot lowest set bit via `x & -x`, plus index encode), instantiated twice: free-entry select and ready-entry select.

## Test plan
- Reset then issue op ADD, both tags `tagFree`, data 5 and 7 → `aluEn`=1 one cycle later with `aluSrc1`=5, `aluSrc2`=7, `aluName`/`aluTag` echoed; `aluEn`=0 next cycle.
- Issue with `issueTag1`=3 pending; two cycles later CDB tag 3 data 0x1234 → dispatch the cycle after broadcast with `aluSrc1`=0x1234.
- Issue with `issueTag1`=`issueTag2`=6 in the same cycle as CDB tag 6 data 9 → both sources 9, dispatch next cycle.
- Fill 8 entries all waiting on tag 2 → `rsFull`=1; further issue ignored; CDB tag 2 → entries dispatch in index order 0..7 on consecutive cycles, `rsFull` drops one cycle after first dispatch.
- CDB with `enCDBWrt`=0 and matching tag, and CDB tag `tagFree` → no capture, no dispatch.
- Entries busy, assert rst=0 for one edge → `aluEn`=0, `rsFull`=0, no later dispatch of old entries.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared widths, reset/free constants and ALU opcodes for the ALU reservation station.
package alu_rs_pkg;

   localparam int unsigned RsSize = 8;
   localparam int unsigned DataW  = 32;
   localparam int unsigned TagW   = 4;
   localparam int unsigned NameW  = 5;
   localparam int unsigned OpW    = 6;

   typedef logic [DataW-1:0] data_bus_t;
   typedef logic [TagW-1:0]  tag_bus_t;
   typedef logic [NameW-1:0] name_bus_t;

   localparam data_bus_t DataFree = '0;
   localparam tag_bus_t  TagFree  = '0;
   localparam name_bus_t NameFree = '0;

   localparam logic Enable  = 1'b1;
   localparam logic Disable = 1'b0;

   localparam logic [OpW-1:0] AluAdd = 6'h01;
   localparam logic [OpW-1:0] AluSub = 6'h02;
   localparam logic [OpW-1:0] AluAnd = 6'h03;
   localparam logic [OpW-1:0] AluOr  = 6'h04;
   localparam logic [OpW-1:0] AluXor = 6'h05;
   localparam logic [OpW-1:0] AluSll = 6'h06;
   localparam logic [OpW-1:0] AluSrl = 6'h07;
   localparam logic [OpW-1:0] AluSlt = 6'h08;

endpackage

// File: rtl/alu_rs_lowbit_sel.sv
// Lowest-set-bit picker: one-hot of the lowest request bit plus its binary index.
module lowbit_sel #(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] req,
   output logic [WIDTH-1:0] onehot,
   output logic [IdxW-1:0]  idx,
   output logic             any
);

   // Two's complement isolates the lowest set bit: x & -x.
   assign onehot = req & (~req + WIDTH'(1));
   assign any    = |req;

   always_comb begin
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (onehot[i]) idx = idx | IdxW'(i);
      end
   end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds decoded ops, snoops the CDB for operands, dispatches one per cycle.
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int unsigned RS_SIZE = RsSize,
   parameter int unsigned DATA_W  = DataW,
   parameter int unsigned TAG_W   = TagW,
   parameter int unsigned NAME_W  = NameW,
   parameter int unsigned OP_W    = OpW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enIssue,
   input  logic [OP_W-1:0]   issueOp,
   input  logic [DATA_W-1:0] issueData1,
   input  logic [DATA_W-1:0] issueData2,
   input  logic [TAG_W-1:0]  issueTag1,
   input  logic [TAG_W-1:0]  issueTag2,
   input  logic [NAME_W-1:0] issueName,
   input  logic [TAG_W-1:0]  issueTag,
   output logic              rsFull,
   input  logic              enCDBWrt,
   input  logic [TAG_W-1:0]  CDBwrtTag,
   input  logic [DATA_W-1:0] CDBwrtData,
   output logic              aluEn,
   output logic [OP_W-1:0]   aluOp,
   output logic [DATA_W-1:0] aluSrc1,
   output logic [DATA_W-1:0] aluSrc2,
   output logic [NAME_W-1:0] aluName,
   output logic [TAG_W-1:0]  aluTag
);

   localparam int unsigned IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
   localparam logic [TAG_W-1:0]  TagFreeW  = TAG_W'(TagFree);
   localparam logic [DATA_W-1:0] DataFreeW = DATA_W'(DataFree);
   localparam logic [NAME_W-1:0] NameFreeW = NAME_W'(NameFree);

   logic [RS_SIZE-1:0] busy_q;
   logic [OP_W-1:0]    op_q   [RS_SIZE];
   logic [DATA_W-1:0]  v1_q   [RS_SIZE];
   logic [DATA_W-1:0]  v2_q   [RS_SIZE];
   logic [TAG_W-1:0]   q1_q   [RS_SIZE];
   logic [TAG_W-1:0]   q2_q   [RS_SIZE];
   logic [NAME_W-1:0]  name_q [RS_SIZE];
   logic [TAG_W-1:0]   tag_q  [RS_SIZE];

   logic [RS_SIZE-1:0] ready;
   logic [RS_SIZE-1:0] free_oh, rdy_oh;
   logic [IdxW-1:0]    free_idx, rdy_idx;
   logic               free_any, rdy_any;
   logic               do_issue;

   function automatic logic cdb_hit(input logic [TAG_W-1:0] t, input logic en,
                                    input logic [TAG_W-1:0] ctag);
      return en && (t == ctag) && (ctag != TagFreeW);
   endfunction

   always_comb begin
      ready = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         ready[i] = busy_q[i] && (q1_q[i] == TagFreeW) && (q2_q[i] == TagFreeW);
      end
   end

   lowbit_sel #(.WIDTH(RS_SIZE)) u_free_sel (
      .req    (~busy_q),
      .onehot (free_oh),
      .idx    (free_idx),
      .any    (free_any)
   );

   lowbit_sel #(.WIDTH(RS_SIZE)) u_rdy_sel (
      .req    (ready),
      .onehot (rdy_oh),
      .idx    (rdy_idx),
      .any    (rdy_any)
   );

   assign rsFull   = &busy_q;
   assign do_issue = enIssue && free_any;

   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_q  <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            q1_q[i] <= TagFreeW;
            q2_q[i] <= TagFreeW;
         end
         aluEn   <= Disable;
         aluOp   <= '0;
         aluSrc1 <= DataFreeW;
         aluSrc2 <= DataFreeW;
         aluName <= NameFreeW;
         aluTag  <= TagFreeW;
      end else begin
         // Issue targets a free slot and dispatch a ready (busy) slot, so the two never collide.
         busy_q <= (busy_q & ~rdy_oh) | (do_issue ? free_oh : '0);
         aluEn  <= rdy_any ? Enable : Disable;
         if (rdy_any) begin
            aluOp   <= op_q[rdy_idx];
            aluSrc1 <= v1_q[rdy_idx];
            aluSrc2 <= v2_q[rdy_idx];
            aluName <= name_q[rdy_idx];
            aluTag  <= tag_q[rdy_idx];
         end
         for (int i = 0; i < RS_SIZE; i++) begin
            if (do_issue && free_oh[i]) begin
               op_q[i]   <= issueOp;
               name_q[i] <= issueName;
               tag_q[i]  <= issueTag;
               if (cdb_hit(issueTag1, enCDBWrt, CDBwrtTag)) begin
                  v1_q[i] <= CDBwrtData;
                  q1_q[i] <= TagFreeW;
               end else begin
                  v1_q[i] <= issueData1;
                  q1_q[i] <= issueTag1;
               end
               if (cdb_hit(issueTag2, enCDBWrt, CDBwrtTag)) begin
                  v2_q[i] <= CDBwrtData;
                  q2_q[i] <= TagFreeW;
               end else begin
                  v2_q[i] <= issueData2;
                  q2_q[i] <= issueTag2;
               end
            end else if (busy_q[i]) begin
               if (cdb_hit(q1_q[i], enCDBWrt, CDBwrtTag)) begin
                  v1_q[i] <= CDBwrtData;
                  q1_q[i] <= TagFreeW;
               end
               if (cdb_hit(q2_q[i], enCDBWrt, CDBwrtTag)) begin
                  v2_q[i] <= CDBwrtData;
                  q2_q[i] <= TagFreeW;
               end
            end
         end
      end
   end

   // Upstream must hold off issue while the station is full.
   assert property (@(posedge clk) disable iff (!rst) !(enIssue && rsFull));

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios plus a randomized run against a slot model.
module tb_alu_rs;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enIssue = 1'b0;
   logic [5:0]  issueOp = '0;
   logic [31:0] issueData1 = '0, issueData2 = '0;
   logic [3:0]  issueTag1 = '0, issueTag2 = '0;
   logic [4:0]  issueName = '0;
   logic [3:0]  issueTag = '0;
   logic        rsFull;
   logic        enCDBWrt = 1'b0;
   logic [3:0]  CDBwrtTag = '0;
   logic [31:0] CDBwrtData = '0;
   logic        aluEn;
   logic [5:0]  aluOp;
   logic [31:0] aluSrc1, aluSrc2;
   logic [4:0]  aluName;
   logic [3:0]  aluTag;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: one record per slot.
   logic        m_busy [8];
   logic [5:0]  m_op   [8];
   logic [31:0] m_v1   [8], m_v2 [8];
   logic [3:0]  m_q1   [8], m_q2 [8];
   logic [4:0]  m_name [8];
   logic [3:0]  m_tag  [8];

   alu_rs u_dut (
      .clk        (clk),
      .rst        (rst),
      .enIssue    (enIssue),
      .issueOp    (issueOp),
      .issueData1 (issueData1),
      .issueData2 (issueData2),
      .issueTag1  (issueTag1),
      .issueTag2  (issueTag2),
      .issueName  (issueName),
      .issueTag   (issueTag),
      .rsFull     (rsFull),
      .enCDBWrt   (enCDBWrt),
      .CDBwrtTag  (CDBwrtTag),
      .CDBwrtData (CDBwrtData),
      .aluEn      (aluEn),
      .aluOp      (aluOp),
      .aluSrc1    (aluSrc1),
      .aluSrc2    (aluSrc2),
      .aluName    (aluName),
      .aluTag     (aluTag)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      enIssue  = 1'b0;
      enCDBWrt = 1'b0;
      issueTag1 = '0;
      issueTag2 = '0;
      CDBwrtTag = '0;
   endtask

   task automatic issue(input logic [5:0] op, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [3:0] t1, input logic [3:0] t2, input logic [4:0] nm,
                        input logic [3:0] tg);
      enIssue = 1'b1; issueOp = op; issueData1 = d1; issueData2 = d2;
      issueTag1 = t1; issueTag2 = t2; issueName = nm; issueTag = tg;
   endtask

   task automatic cdb(input logic en, input logic [3:0] t, input logic [31:0] d);
      enCDBWrt = en; CDBwrtTag = t; CDBwrtData = d;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      step();
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         m_busy[i] = 1'b0; m_q1[i] = '0; m_q2[i] = '0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (aluEn !== 1'b0) begin n_fail++; $display("FAIL reset_aluEn got %0b want 0", aluEn); end
      n_checks++; if (aluOp !== 6'h0) begin n_fail++; $display("FAIL reset_aluOp got %0h want 0", aluOp); end
      n_checks++; if (aluSrc1 !== 32'h0 || aluSrc2 !== 32'h0) begin
         n_fail++; $display("FAIL reset_src got %0h/%0h want 0/0", aluSrc1, aluSrc2); end
      n_checks++; if (aluName !== 5'h0 || aluTag !== 4'h0) begin
         n_fail++; $display("FAIL reset_name_tag got %0h/%0h want 0/0", aluName, aluTag); end
      n_checks++; if (rsFull !== 1'b0) begin n_fail++; $display("FAIL reset_rsFull got %0b want 0", rsFull); end
   endtask

   task automatic test_add();
      issue(6'h01, 32'd5, 32'd7, 4'd0, 4'd0, 5'd9, 4'd5);
      step();
      idle();
      n_checks++; if (aluEn !== 1'b0) begin n_fail++; $display("FAIL add_early got %0b want 0", aluEn); end
      step();
      n_checks++; if (aluEn !== 1'b1 || aluOp !== 6'h01 || aluSrc1 !== 32'd5 || aluSrc2 !== 32'd7 ||
                      aluName !== 5'd9 || aluTag !== 4'd5) begin
         n_fail++;
         $display("FAIL add_dispatch got en=%0b op=%0h s1=%0d s2=%0d nm=%0d tg=%0d want 1 01 5 7 9 5",
                  aluEn, aluOp, aluSrc1, aluSrc2, aluName, aluTag);
      end
      step();
      n_checks++; if (aluEn !== 1'b0) begin n_fail++; $display("FAIL add_pulse got %0b want 0", aluEn); end
   endtask

   task automatic test_cdb_capture();
      issue(6'h02, 32'hdead, 32'h22, 4'd3, 4'd0, 5'd4, 4'd7);
      step();
      idle();
      step();
      n_checks++; if (aluEn !== 1'b0) begin n_fail++; $display("FAIL capture_wait got %0b want 0", aluEn); end
      cdb(1'b1, 4'd3, 32'h1234);
      step();
      idle();
      n_checks++; if (aluEn !== 1'b0) begin n_fail++; $display("FAIL capture_latency got %0b want 0", aluEn); end
      step();
      n_checks++; if (aluEn !== 1'b1 || aluSrc1 !== 32'h1234 || aluSrc2 !== 32'h22 || aluTag !== 4'd7) begin
         n_fail++;
         $display("FAIL capture_dispatch got en=%0b s1=%0h s2=%0h tg=%0d want 1 1234 22 7",
                  aluEn, aluSrc1, aluSrc2, aluTag);
      end
      step();
   endtask

   task automatic test_forward();
      issue(6'h03, 32'haaaa, 32'hbbbb, 4'd6, 4'd6, 5'd12, 4'd8);
      cdb(1'b1, 4'd6, 32'd9);
      step();
      idle();
      step();
      n_checks++; if (aluEn !== 1'b1 || aluSrc1 !== 32'd9 || aluSrc2 !== 32'd9 || aluName !== 5'd12) begin
         n_fail++;
         $display("FAIL forward got en=%0b s1=%0h s2=%0h nm=%0d want 1 9 9 12", aluEn, aluSrc1, aluSrc2, aluName);
      end
      step();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         issue(6'h04, 32'h0, 32'(i * 3), 4'd2, 4'd0, 5'(i + 16), 4'(i + 8));
         step();
      end
      idle();
      n_checks++; if (rsFull !== 1'b1) begin n_fail++; $display("FAIL fill_full got %0b want 1", rsFull); end
      cdb(1'b1, 4'd2, 32'hab);
      step();
      idle();
      n_checks++; if (aluEn !== 1'b0 || rsFull !== 1'b1) begin
         n_fail++; $display("FAIL fill_capture got en=%0b full=%0b want 0 1", aluEn, rsFull); end
      for (int i = 0; i < 8; i++) begin
         step();
         n_checks++; if (aluEn !== 1'b1 || aluName !== 5'(i + 16) || aluSrc1 !== 32'hab ||
                         aluSrc2 !== 32'(i * 3)) begin
            n_fail++;
            $display("FAIL fill_order[%0d] got en=%0b nm=%0d s1=%0h s2=%0h want 1 %0d ab %0h",
                     i, aluEn, aluName, aluSrc1, aluSrc2, i + 16, i * 3);
         end
         if (i == 0) begin
            n_checks++; if (rsFull !== 1'b0) begin n_fail++; $display("FAIL fill_drop got %0b want 0", rsFull); end
         end
      end
      step();
      n_checks++; if (aluEn !== 1'b0) begin n_fail++; $display("FAIL fill_end got %0b want 0", aluEn); end
   endtask

   task automatic test_no_capture();
      issue(6'h05, 32'h0, 32'h1, 4'd4, 4'd0, 5'd3, 4'd9);
      step();
      idle();
      cdb(1'b0, 4'd4, 32'h5555);
      step();
      n_checks++; if (aluEn !== 1'b0) begin n_fail++; $display("FAIL nocap_disabled got %0b want 0", aluEn); end
      cdb(1'b1, 4'd0, 32'h6666);
      step();
      idle();
      n_checks++; if (aluEn !== 1'b0) begin n_fail++; $display("FAIL nocap_tagfree got %0b want 0", aluEn); end
      step();
      n_checks++; if (aluEn !== 1'b0) begin n_fail++; $display("FAIL nocap_later got %0b want 0", aluEn); end
      cdb(1'b1, 4'd4, 32'h7777);
      step();
      idle();
      step();
      n_checks++; if (aluEn !== 1'b1 || aluSrc1 !== 32'h7777) begin
         n_fail++; $display("FAIL nocap_release got en=%0b s1=%0h want 1 7777", aluEn, aluSrc1); end
      step();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         issue(6'h06, 32'h0, 32'h0, 4'd5, 4'd0, 5'(i), 4'(i + 1));
         step();
      end
      rst = 1'b0;
      issue(6'h07, 32'd1, 32'd2, 4'd0, 4'd0, 5'd30, 4'd15);
      cdb(1'b1, 4'd5, 32'h99);
      step();
      rst = 1'b1;
      idle();
      n_checks++; if (aluEn !== 1'b0 || rsFull !== 1'b0) begin
         n_fail++; $display("FAIL midreset_state got en=%0b full=%0b want 0 0", aluEn, rsFull); end
      cdb(1'b1, 4'd5, 32'h99);
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (aluEn !== 1'b0) begin
            n_fail++; $display("FAIL midreset_stale[%0d] got %0b want 0", i, aluEn); end
      end
   endtask

   task automatic test_random();
      int k, f, nb;
      logic        e_en;
      logic [5:0]  e_op;
      logic [31:0] e_s1, e_s2;
      logic [4:0]  e_nm;
      logic [3:0]  e_tg;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         nb = 0;
         for (int i = 0; i < 8; i++) nb += int'(m_busy[i]);
         idle();
         if (nb < 8 && $urandom_range(0, 3) != 0) begin
            issue(6'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 7)),
                  ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 7)),
                  5'($urandom), 4'($urandom));
         end
         if ($urandom_range(0, 1) == 0) cdb(1'b1, 4'($urandom_range(0, 7)), $urandom);

         // Oldest-index ready slot goes to the ALU; readiness is judged before this cycle's CDB.
         k = -1;
         f = -1;
         for (int i = 0; i < 8; i++) begin
            if (k < 0 && m_busy[i] && m_q1[i] == 4'd0 && m_q2[i] == 4'd0) k = i;
            if (f < 0 && !m_busy[i]) f = i;
         end
         e_en = (k >= 0);
         if (e_en) begin
            e_op = m_op[k]; e_s1 = m_v1[k]; e_s2 = m_v2[k]; e_nm = m_name[k]; e_tg = m_tag[k];
            m_busy[k] = 1'b0;
         end
         for (int i = 0; i < 8; i++) begin
            if (m_busy[i] && enCDBWrt && CDBwrtTag != 4'd0) begin
               if (m_q1[i] == CDBwrtTag) begin m_v1[i] = CDBwrtData; m_q1[i] = 4'd0; end
               if (m_q2[i] == CDBwrtTag) begin m_v2[i] = CDBwrtData; m_q2[i] = 4'd0; end
            end
         end
         if (enIssue) begin
            m_busy[f] = 1'b1; m_op[f] = issueOp; m_name[f] = issueName; m_tag[f] = issueTag;
            m_v1[f] = issueData1; m_q1[f] = issueTag1; m_v2[f] = issueData2; m_q2[f] = issueTag2;
            if (enCDBWrt && CDBwrtTag != 4'd0 && issueTag1 == CDBwrtTag) begin
               m_v1[f] = CDBwrtData; m_q1[f] = 4'd0;
            end
            if (enCDBWrt && CDBwrtTag != 4'd0 && issueTag2 == CDBwrtTag) begin
               m_v2[f] = CDBwrtData; m_q2[f] = 4'd0;
            end
         end
         nb = 0;
         for (int i = 0; i < 8; i++) nb += int'(m_busy[i]);

         step();
         n_checks++; if (aluEn !== e_en) begin
            n_fail++; $display("FAIL rand_en[%0d] got %0b want %0b", cyc, aluEn, e_en); end
         n_checks++; if (rsFull !== (nb == 8)) begin
            n_fail++; $display("FAIL rand_full[%0d] got %0b want %0b", cyc, rsFull, nb == 8); end
         if (e_en) begin
            n_checks++; if (aluOp !== e_op || aluSrc1 !== e_s1 || aluSrc2 !== e_s2 ||
                            aluName !== e_nm || aluTag !== e_tg) begin
               n_fail++;
               $display("FAIL rand_payload[%0d] got %0h %0h %0h %0h %0h want %0h %0h %0h %0h %0h",
                        cyc, aluOp, aluSrc1, aluSrc2, aluName, aluTag, e_op, e_s1, e_s2, e_nm, e_tg);
            end
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_add();
      test_cdb_capture();
      test_forward();
      test_fill();
      test_no_capture();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
